mcb_burst_rw_controller: RTL
============================

Name: mcb_burst_rw_controller

Overview:
Parametrised burst-capable successor to the single-word MCB port controller. Moves 1..MAX_BURST words per operation between a host-side streaming interface and one MCB user port (command, write and read FIFOs). It sits between the main acquisition/readout controller and the SP601 DDR2 MCB. It adds selectable precharge mode, protocol-error capture and a stall timeout.

Parameters:
DATA_WIDTH, 32, MCB port data width; mask width is DATA_WIDTH/8
ADDR_WIDTH, 30, MCB byte address width
MAX_BURST, 64, largest burst in words; must be at most 64
BL_WIDTH, 7, width of the burst_len input; must hold the value MAX_BURST
AUTO_PRECHARGE, 1, 1 = issue write_p/read_p (3'b010/3'b011); 0 = issue write/read (3'b000/3'b001)
TIMEOUT, 1024, stall cycles allowed before abort; 0 disables the timeout

Ports:
clk  in  1  system clock; the only clock
reset  in  1  asynchronous, active-low reset
ready  out  1  1 = IDLE, a new mem_op is accepted
mem_op  in  1  start strobe; sampled only while ready=1
read_write  in  1  1 = read, 0 = write
addr  in  ADDR_WIDTH  byte start address
burst_len  in  BL_WIDTH  words to transfer
wr_data  in  DATA_WIDTH  host write word
wr_valid  in  1  wr_data is valid
wr_accept  out  1  combinational; the word is consumed this cycle
rd_data  out  DATA_WIDTH  read word (registered)
rd_valid  out  1  one-cycle qualifier for rd_data
done  out  1  one-cycle end-of-operation strobe
error  out  1  sticky; cleared when the next mem_op is accepted
pX_cmd_en, pX_cmd_instr[2:0], pX_cmd_bl[5:0], pX_cmd_addr[ADDR_WIDTH-1:0]  out  MCB command port
pX_cmd_full  in  1  command FIFO full
pX_wr_en, pX_wr_mask[DATA_WIDTH/8-1:0], pX_wr_data[DATA_WIDTH-1:0]  out  MCB write port
pX_wr_full, pX_wr_empty, pX_wr_underrun, pX_wr_error  in  1 each
pX_rd_en  out  1  MCB read enable
pX_rd_data  in  DATA_WIDTH  MCB read data
pX_rd_empty, pX_rd_overflow, pX_rd_error  in  1 each

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; ready=1; done, error, rd_valid, pX_cmd_en = 0; rd_data=0.
  - pX_cmd_instr = read-type code for the AUTO_PRECHARGE mode; pX_cmd_bl=0; pX_cmd_addr=0.
  - Reset asserted mid-operation aborts immediately with no done. Words already in the MCB FIFOs are not flushed.
- Burst length: burst_len=0 is treated as 1; values above MAX_BURST are clamped. The effective length N is latched on accept and pX_cmd_bl = N-1.
- Address: pX_cmd_addr = latched addr with the low log2(DATA_WIDTH/8) bits forced to 0.
- pX_wr_mask is tied to 0.
- States:
  - IDLE: when mem_op=1, latch addr, N and direction; clear error; ready drops to 0 the next cycle. Go to WR_FILL (write) or RD_CMD (read).
  - WR_FILL: pX_wr_en = wr_accept = wr_valid & ~pX_wr_full; pX_wr_data = wr_data (pass-through). Count accepted words; after the Nth go to WR_CMD.
  - WR_CMD: when ~pX_cmd_full and ~pX_wr_empty, pulse pX_cmd_en for exactly one cycle, then go to FINISH.
  - RD_CMD: wait for pX_rd_empty & ~pX_cmd_full, pulse pX_cmd_en for one cycle, then go to RD_DRAIN.
  - RD_DRAIN: pX_rd_en = ~pX_rd_empty (0 in every other state). Each pop registers rd_data <= pX_rd_data and asserts rd_valid on the next cycle. After the Nth pop go to FINISH.
  - FINISH: done=1 for one cycle; ready returns to 1 on the same cycle; go to IDLE.
- Latency:
  - Write, N=1, no stalls: mem_op at cycle 0, wr_accept at cycle 1, pX_cmd_en at cycle 2, done at cycle 3.
  - Read: done coincides with the rd_valid of the last word.
- Errors:
  - pX_wr_underrun or pX_wr_error during a write sets error; the operation continues.
  - pX_rd_overflow or pX_rd_error during a read sets error; the operation continues.
  - Timeout: if no word moves and no command is issued for TIMEOUT consecutive cycles in any non-IDLE state, set error, pulse done and return to IDLE.
- mem_op while ready=0 is ignored.
- wr_valid outside WR_FILL is ignored and wr_accept stays 0.

Test Plan:
- Reset: reset=0 mid-read -> all outputs at reset values, ready=1, no done.
- Single write: addr=0x103, N=1, wr_data=0xDEADBEEF -> pX_cmd_addr=0x100, pX_cmd_bl=0, pX_cmd_instr=3'b010, done at cycle 3, one pX_cmd_en.
- Burst write with pX_wr_full toggling: N=16 -> exactly 16 wr_accept; pX_cmd_en only after the 16th word; pX_cmd_bl=15.
- Burst read: N=64, model returns 0..63 with random pX_rd_empty gaps -> 64 rd_valid in order 0..63; done with the last word; pX_cmd_instr=3'b011.
- Edge lengths: burst_len=0 -> 1 word transferred; burst_len=100 -> 64 words, pX_cmd_bl=63. With AUTO_PRECHARGE=0 the instr codes are 3'b000 and 3'b001.
- Fault handling: read with pX_rd_empty held 1, TIMEOUT=16 -> error=1 and done after 16 stalled cycles, ready=1. pX_rd_overflow pulse -> error sticky until the next accepted mem_op.

Source files
------------

// File: rtl/mcb_burst_rw_controller.sv
// Burst read/write controller for one MCB user port: streams 1..MAX_BURST words
// between a host handshake and the MCB command/write/read FIFOs, with error capture and stall timeout.
module mcb_burst_rw_controller #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 30,
    parameter int MAX_BURST      = 64,
    parameter int BL_WIDTH       = 7,
    parameter int AUTO_PRECHARGE = 1,
    parameter int TIMEOUT        = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    ready,
    input  logic                    mem_op,
    input  logic                    read_write,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [BL_WIDTH-1:0]     burst_len,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_valid,
    output logic                    wr_accept,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    done,
    output logic                    error,
    output logic                    pX_cmd_en,
    output logic [2:0]              pX_cmd_instr,
    output logic [5:0]              pX_cmd_bl,
    output logic [ADDR_WIDTH-1:0]   pX_cmd_addr,
    input  logic                    pX_cmd_full,
    output logic                    pX_wr_en,
    output logic [DATA_WIDTH/8-1:0] pX_wr_mask,
    output logic [DATA_WIDTH-1:0]   pX_wr_data,
    input  logic                    pX_wr_full,
    input  logic                    pX_wr_empty,
    input  logic                    pX_wr_underrun,
    input  logic                    pX_wr_error,
    output logic                    pX_rd_en,
    input  logic [DATA_WIDTH-1:0]   pX_rd_data,
    input  logic                    pX_rd_empty,
    input  logic                    pX_rd_overflow,
    input  logic                    pX_rd_error
);
    localparam int LW = $clog2(MAX_BURST + 1);
    localparam int AB = $clog2(DATA_WIDTH / 8);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [2:0] INSTR_WR = (AUTO_PRECHARGE != 0) ? 3'b010 : 3'b000;
    localparam logic [2:0] INSTR_RD = INSTR_WR | 3'b001;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << AB) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_FILL, S_WR_CMD, S_RD_CMD, S_RD_DRAIN, S_FINISH
    } state_t;

    state_t r_state, w_state_fsm, w_state_next;

    logic [LW-1:0]         r_len, r_cnt, w_len_eff;
    logic                  r_error, r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [2:0]            r_cmd_instr;
    logic [5:0]            r_cmd_bl;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic                  w_ready, w_accept, w_wr_accept, w_cmd_en, w_rd_en;
    logic                  w_last, w_busy, w_progress, w_timeout, w_err_in;

    // FINISH behaves like IDLE for acceptance so ready can rise together with done.
    assign w_ready    = (r_state == S_IDLE) || (r_state == S_FINISH);
    assign w_accept   = w_ready & mem_op;
    assign w_last     = (r_cnt == r_len - LW'(1));
    assign w_busy     = ~w_ready;
    assign w_progress = w_cmd_en | w_wr_accept | w_rd_en;
    assign w_err_in   = (((r_state == S_WR_FILL) || (r_state == S_WR_CMD)) & (pX_wr_underrun | pX_wr_error))
                      | (((r_state == S_RD_CMD) || (r_state == S_RD_DRAIN)) & (pX_rd_overflow | pX_rd_error));

    always_comb begin
        if (burst_len == '0)
            w_len_eff = LW'(1);
        else if (burst_len > BL_WIDTH'(MAX_BURST))
            w_len_eff = LW'(MAX_BURST);
        else
            w_len_eff = LW'(burst_len);
    end

    always_comb begin
        w_state_fsm = r_state;
        w_wr_accept = 1'b0;
        w_cmd_en    = 1'b0;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE, S_FINISH: begin
                w_state_fsm = S_IDLE;
                if (mem_op)
                    w_state_fsm = read_write ? S_RD_CMD : S_WR_FILL;
            end
            S_WR_FILL: begin
                w_wr_accept = wr_valid & ~pX_wr_full;
                if (w_wr_accept && w_last)
                    w_state_fsm = S_WR_CMD;
            end
            S_WR_CMD: begin
                if (!pX_cmd_full && !pX_wr_empty) begin
                    w_cmd_en    = 1'b1;
                    w_state_fsm = S_FINISH;
                end
            end
            S_RD_CMD: begin
                // Only issue once stale read data is gone, so every popped word belongs to this burst.
                if (pX_rd_empty && !pX_cmd_full) begin
                    w_cmd_en    = 1'b1;
                    w_state_fsm = S_RD_DRAIN;
                end
            end
            S_RD_DRAIN: begin
                w_rd_en = ~pX_rd_empty;
                if (w_rd_en && w_last)
                    w_state_fsm = S_FINISH;
            end
            default: w_state_fsm = S_IDLE;
        endcase
    end

    assign w_state_next = w_timeout ? S_FINISH : w_state_fsm;

    generate
        if (TIMEOUT > 0) begin : g_timeout
            logic [TW-1:0] r_stall;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    r_stall <= '0;
                else if (!w_busy || w_progress || w_timeout)
                    r_stall <= '0;
                else
                    r_stall <= r_stall + TW'(1);
            end
            assign w_timeout = w_busy & ~w_progress & (r_stall == TW'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_len       <= LW'(1);
            r_cnt       <= '0;
            r_error     <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_cmd_instr <= INSTR_RD;
            r_cmd_bl    <= '0;
            r_cmd_addr  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rd_valid <= w_rd_en;
            if (w_rd_en)
                r_rd_data <= pX_rd_data;
            if (w_accept) begin
                r_len       <= w_len_eff;
                r_cnt       <= '0;
                r_error     <= 1'b0;
                r_cmd_instr <= read_write ? INSTR_RD : INSTR_WR;
                r_cmd_bl    <= 6'(w_len_eff - LW'(1));
                r_cmd_addr  <= addr & ADDR_MASK;
            end else begin
                if (w_wr_accept || w_rd_en)
                    r_cnt <= r_cnt + LW'(1);
                if (w_err_in || w_timeout)
                    r_error <= 1'b1;
            end
        end
    end

    assign ready        = w_ready;
    assign done         = (r_state == S_FINISH);
    assign error        = r_error;
    assign wr_accept    = w_wr_accept;
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign pX_cmd_en    = w_cmd_en;
    assign pX_cmd_instr = r_cmd_instr;
    assign pX_cmd_bl    = r_cmd_bl;
    assign pX_cmd_addr  = r_cmd_addr;
    assign pX_wr_en     = w_wr_accept;
    assign pX_wr_mask   = '0;
    assign pX_wr_data   = wr_data;
    assign pX_rd_en     = w_rd_en;
endmodule
